// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the register-file write-back block.
//   XLEN   : width of result data and register-file write data
//   NREG   : number of architectural registers (x0 reads as zero)
//   ADDR_W : register index width
//   grant_e: which producer owns the write port (ALU or load unit)
package reg_writeback_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int ADDR_W = $clog2(NREG);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

endpackage : reg_writeback_pkg

// File: rtl/reg_writeback_scoreboard.sv
// Per-register busy scoreboard for the decode stage.
//   clk, rst          : clock, asynchronous active-high reset
//   issue_valid_i     : decode wants to issue an instruction writing issue_rd_i
//   issue_rd_i        : destination of the issuing instruction
//   issue_ready_o     : issue accepted (destination has no pending write)
//   clr_valid_i       : a result is granted onto the write port this cycle
//   clr_rd_i          : destination of the granted result
//   read1_i, read2_i  : decode source registers
//   busy1_o, busy2_o  : the source register has a pending write
module wb_scoreboard
    import reg_writeback_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    output logic              issue_ready_o,
    input  logic              clr_valid_i,
    input  logic [ADDR_W-1:0] clr_rd_i,
    input  logic [ADDR_W-1:0] read1_i,
    input  logic [ADDR_W-1:0] read2_i,
    output logic              busy1_o,
    output logic              busy2_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            issue_fire;

    // One pending write per register: a second issue to a busy destination
    // waits until the first result has been granted.
    assign issue_ready_o = !busy_q[issue_rd_i] || (issue_rd_i == '0);
    assign issue_fire    = issue_valid_i && issue_ready_o;

    // A register granted this cycle still reads busy: its value only lands in
    // the register file on the coming edge.
    assign busy1_o = busy_q[read1_i] && (read1_i != '0);
    assign busy2_o = busy_q[read2_i] && (read2_i != '0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        busy_d = busy_q;
        if (clr_valid_i) begin
            busy_d[clr_rd_i] = 1'b0;
        end
        // Set is applied after clear so a same-edge set and clear leaves the
        // register busy for the newly issued instruction.
        if (issue_fire && (issue_rd_i != '0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples its inputs from before the edge.
            busy_q <= busy_d;
        end
    end

endmodule : wb_scoreboard

// File: rtl/reg_writeback.sv
// Write side of the register file: arbitrates ALU and load results onto the
// single write port and tracks pending writes for RAW-hazard stalls.
//   clk, rst                    : clock, asynchronous active-high reset
//   issueValid/issueRd/issueReady : decode issue handshake (sets busy bit)
//   read1/read2 -> busy1/busy2  : scoreboard queries for decode sources
//   aluValid/aluRd/aluData/aluReady : ALU result handshake
//   memValid/memRd/memData/memReady : load result handshake
//   regWrite/writeReg/writeData : registered register-file write port
module reg_writeback
    import reg_writeback_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueRd,
    output logic              issueReady,
    input  logic [ADDR_W-1:0] read1,
    input  logic [ADDR_W-1:0] read2,
    output logic              busy1,
    output logic              busy2,
    input  logic              aluValid,
    input  logic [ADDR_W-1:0] aluRd,
    input  logic [XLEN-1:0]   aluData,
    output logic              aluReady,
    input  logic              memValid,
    input  logic [ADDR_W-1:0] memRd,
    input  logic [XLEN-1:0]   memData,
    output logic              memReady,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [XLEN-1:0]   writeData
);

    grant_e            last_grant_q;
    grant_e            last_grant_d;
    logic              contested;
    logic              grant_valid;
    logic [ADDR_W-1:0] grant_rd;
    logic [XLEN-1:0]   grant_data;

    logic              reg_write_q;
    logic [ADDR_W-1:0] write_reg_q;
    logic [XLEN-1:0]   write_data_q;

    // Readies depend only on the valids and the round-robin pointer, never on
    // the write port, so producers see no combinational path back to themselves.
    assign contested = aluValid && memValid;
    assign aluReady  = aluValid && (!memValid || (last_grant_q == GRANT_MEM));
    assign memReady  = memValid && (!aluValid || (last_grant_q == GRANT_ALU));

    always_comb begin
        grant_valid  = 1'b0;
        grant_rd     = '0;
        grant_data   = '0;
        last_grant_d = last_grant_q;
        if (aluReady) begin
            grant_valid = 1'b1;
            grant_rd    = aluRd;
            grant_data  = aluData;
        end else if (memReady) begin
            grant_valid = 1'b1;
            grant_rd    = memRd;
            grant_data  = memData;
        end
        // The pointer only moves when both sources competed; an uncontested
        // grant does not cost the other source its next turn.
        if (contested) begin
            last_grant_d = aluReady ? GRANT_ALU : GRANT_MEM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GRANT_MEM;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            // Results for x0 are consumed but never written.
            reg_write_q  <= grant_valid && (grant_rd != '0);
            if (grant_valid) begin
                write_reg_q  <= grant_rd;
                write_data_q <= grant_data;
            end
        end
    end

    assign regWrite  = reg_write_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;

    wb_scoreboard u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (issueValid),
        .issue_rd_i    (issueRd),
        .issue_ready_o (issueReady),
        .clr_valid_i   (grant_valid),
        .clr_rd_i      (grant_rd),
        .read1_i       (read1),
        .read2_i       (read2),
        .busy1_o       (busy1),
        .busy2_o       (busy2)
    );

endmodule : reg_writeback

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: a per-cycle vector table covering
// issue/scoreboard, arbitration and write-port behaviour, followed by a
// hand-written asynchronous-reset sequence.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        issueValid;
    logic [4:0]  issueRd;
    logic        issueReady;
    logic [4:0]  read1;
    logic [4:0]  read2;
    logic        busy1;
    logic        busy2;
    logic        aluValid;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        aluReady;
    logic        memValid;
    logic [4:0]  memRd;
    logic [31:0] memData;
    logic        memReady;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    reg_writeback dut (
        .clk        (clk),
        .rst        (rst),
        .issueValid (issueValid),
        .issueRd    (issueRd),
        .issueReady (issueReady),
        .read1      (read1),
        .read2      (read2),
        .busy1      (busy1),
        .busy2      (busy2),
        .aluValid   (aluValid),
        .aluRd      (aluRd),
        .aluData    (aluData),
        .aluReady   (aluReady),
        .memValid   (memValid),
        .memRd      (memRd),
        .memData    (memData),
        .memReady   (memReady),
        .regWrite   (regWrite),
        .writeReg   (writeReg),
        .writeData  (writeData)
    );

    // One cycle of stimulus: inputs, expected combinational outputs before the
    // edge, expected write-port outputs after the edge.
    typedef struct {
        logic [31:0] iv, ird, av, ard, ad, mv, mrd, md, r1, r2;
        logic [31:0] e_ir, e_ar, e_mr, e_b1, e_b2;
        logic [31:0] e_rw, e_wr, e_wd;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issueValid = 1'b0; issueRd = '0;
        aluValid = 1'b0; aluRd = '0; aluData = '0;
        memValid = 1'b0; memRd = '0; memData = '0;
        read1 = '0; read2 = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            iv ird av ard ad           mv mrd md    r1 r2 | ir ar mr b1 b2 | rw wr wd
        vecs[0]  = '{1, 5, 0, 0, 0,            0, 0,  0,    5, 0,   1, 0, 0, 0, 0,   0, 0, 0};
        vecs[1]  = '{0, 5, 1, 5, 32'hDEADBEEF, 0, 0,  0,    5, 0,   0, 1, 0, 1, 0,   1, 5, 32'hDEADBEEF};
        vecs[2]  = '{0, 5, 0, 0, 0,            0, 0,  0,    5, 0,   1, 0, 0, 0, 0,   0, 5, 32'hDEADBEEF};
        vecs[3]  = '{0, 0, 1, 3, 32'h33,       1, 4,  32'h44, 3, 4, 1, 1, 0, 0, 0,   1, 3, 32'h33};
        vecs[4]  = '{0, 0, 1, 3, 32'h33,       1, 4,  32'h44, 3, 4, 1, 0, 1, 0, 0,   1, 4, 32'h44};
        vecs[5]  = '{0, 0, 1, 3, 32'h33,       1, 4,  32'h44, 3, 4, 1, 1, 0, 0, 0,   1, 3, 32'h33};
        vecs[6]  = '{0, 0, 0, 0, 0,            1, 6,  32'h66, 0, 0, 1, 0, 1, 0, 0,   1, 6, 32'h66};
        vecs[7]  = '{0, 0, 1, 8, 32'h88,       0, 0,  0,    0, 0,   1, 1, 0, 0, 0,   1, 8, 32'h88};
        vecs[8]  = '{0, 0, 1, 10, 32'hA0,      1, 11, 32'hB0, 0, 0, 1, 0, 1, 0, 0,   1, 11, 32'hB0};
        vecs[9]  = '{1, 0, 1, 0, 32'h1234,     0, 0,  0,    0, 0,   1, 1, 0, 0, 0,   0, 0, 32'h1234};
        vecs[10] = '{0, 0, 0, 0, 0,            0, 0,  0,    0, 0,   1, 0, 0, 0, 0,   0, 0, 32'h1234};
        vecs[11] = '{1, 7, 0, 0, 0,            0, 0,  0,    7, 0,   1, 0, 0, 0, 0,   0, 0, 32'h1234};
        vecs[12] = '{1, 7, 0, 0, 0,            0, 0,  0,    7, 0,   0, 0, 0, 1, 0,   0, 0, 32'h1234};
        vecs[13] = '{1, 7, 1, 7, 32'h77,       0, 0,  0,    7, 0,   0, 1, 0, 1, 0,   1, 7, 32'h77};
        vecs[14] = '{1, 7, 0, 0, 0,            0, 0,  0,    7, 0,   1, 0, 0, 0, 0,   0, 7, 32'h77};
        vecs[15] = '{0, 0, 0, 0, 0,            0, 0,  0,    7, 7,   1, 0, 0, 1, 1,   0, 7, 32'h77};
        vecs[16] = '{1, 12, 1, 12, 32'hC0,     0, 0,  0,    12, 0,  1, 1, 0, 0, 0,   1, 12, 32'hC0};
        vecs[17] = '{0, 0, 0, 0, 0,            1, 7,  32'h70, 12, 7, 1, 0, 1, 1, 1,  1, 7, 32'h70};
        vecs[18] = '{0, 0, 0, 0, 0,            0, 0,  0,    12, 7,  1, 0, 0, 1, 0,   0, 7, 32'h70};

        // Reset then idle.
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset regWrite", {31'b0, regWrite}, 32'h0);
        check("reset writeReg", {27'b0, writeReg}, 32'h0);
        check("reset writeData", writeData, 32'h0);
        check("reset aluReady", {31'b0, aluReady}, 32'h0);
        check("reset memReady", {31'b0, memReady}, 32'h0);
        for (int r = 0; r < 32; r++) begin
            read1 = 5'(r);
            read2 = 5'(31 - r);
            #1;
            check($sformatf("reset busy1 r%0d", r), {31'b0, busy1}, 32'h0);
            check($sformatf("reset busy2 r%0d", 31 - r), {31'b0, busy2}, 32'h0);
        end

        // Table-driven cycles.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            issueValid = vecs[i].iv[0];
            issueRd    = vecs[i].ird[4:0];
            aluValid   = vecs[i].av[0];
            aluRd      = vecs[i].ard[4:0];
            aluData    = vecs[i].ad;
            memValid   = vecs[i].mv[0];
            memRd      = vecs[i].mrd[4:0];
            memData    = vecs[i].md;
            read1      = vecs[i].r1[4:0];
            read2      = vecs[i].r2[4:0];
            #1;
            check($sformatf("v%0d issueReady", i), {31'b0, issueReady}, vecs[i].e_ir);
            check($sformatf("v%0d aluReady", i), {31'b0, aluReady}, vecs[i].e_ar);
            check($sformatf("v%0d memReady", i), {31'b0, memReady}, vecs[i].e_mr);
            check($sformatf("v%0d busy1", i), {31'b0, busy1}, vecs[i].e_b1);
            check($sformatf("v%0d busy2", i), {31'b0, busy2}, vecs[i].e_b2);
            @(posedge clk);
            #1;
            check($sformatf("v%0d regWrite", i), {31'b0, regWrite}, vecs[i].e_rw);
            check($sformatf("v%0d writeReg", i), {27'b0, writeReg}, vecs[i].e_wr);
            check($sformatf("v%0d writeData", i), writeData, vecs[i].e_wd);
        end

        // Asynchronous reset mid-cycle with a pending write to x9 in flight.
        // First a contested cycle moves the round-robin pointer to ALU.
        @(negedge clk);
        idle_inputs();
        issueValid = 1'b1; issueRd = 5'd9;
        aluValid = 1'b1; aluRd = 5'd1; aluData = 32'h11;
        memValid = 1'b1; memRd = 5'd2; memData = 32'h22;
        #1;
        check("rst pre aluReady", {31'b0, aluReady}, 32'h1);
        check("rst pre memReady", {31'b0, memReady}, 32'h0);
        @(posedge clk);
        #1;
        check("rst pre regWrite", {31'b0, regWrite}, 32'h1);
        check("rst pre writeReg", {27'b0, writeReg}, 32'd1);
        @(negedge clk);
        idle_inputs();
        memValid = 1'b1; memRd = 5'd9; memData = 32'h99;
        read1 = 5'd9; issueRd = 5'd9;
        #1;
        check("rst x9 busy before", {31'b0, busy1}, 32'h1);
        check("rst x9 memReady", {31'b0, memReady}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rst async regWrite", {31'b0, regWrite}, 32'h0);
        check("rst async writeReg", {27'b0, writeReg}, 32'h0);
        check("rst async writeData", writeData, 32'h0);
        check("rst async busy x9", {31'b0, busy1}, 32'h0);
        check("rst async issueReady x9", {31'b0, issueReady}, 32'h1);
        memValid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst release regWrite", {31'b0, regWrite}, 32'h0);
        check("rst release busy x9", {31'b0, busy1}, 32'h0);
        // Pointer back at MEM after reset: a contested cycle grants ALU.
        @(negedge clk);
        aluValid = 1'b1; aluRd = 5'd13; aluData = 32'hD0;
        memValid = 1'b1; memRd = 5'd14; memData = 32'hE0;
        #1;
        check("rst ptr aluReady", {31'b0, aluReady}, 32'h1);
        check("rst ptr memReady", {31'b0, memReady}, 32'h0);
        @(posedge clk);
        #1;
        check("rst ptr writeReg", {27'b0, writeReg}, 32'd13);
        check("rst ptr writeData", writeData, 32'hD0);
        @(negedge clk);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_reg_writeback
